// File: rtl/cpu_boot_pkg.sv
// ============================================================================
//  Module   : cpu_boot_pkg
//  Purpose  : Shared types and default constants for the CPU boot sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_boot_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int IDX_W  = 9;

  localparam logic [ADDR_W-1:0] DEF_LOAD_BASE    = 8'd0;
  localparam int                DEF_LOAD_LEN     = 5;
  localparam logic [ADDR_W-1:0] DEF_DUMP_BASE    = 8'd5;
  localparam int                DEF_DUMP_LEN     = 4;
  localparam int                DEF_START_CYCLES = 2;
  localparam int                DEF_TIMEOUT      = 65535;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_DUMP  = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  // 9-bit index folded onto the 8-bit address space, wrapping 255 -> 0.
  function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [IDX_W-1:0]  idx);
    return base + idx[ADDR_W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_boot_sequencer.sv
// ============================================================================
//  Module   : cpu_boot_sequencer
//  Purpose  : Load operands into data_mem, release the core, await halt, dump results.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_boot_sequencer
  import cpu_boot_pkg::*;
#(
  parameter logic [ADDR_W-1:0] LOAD_BASE    = DEF_LOAD_BASE,
  parameter int                LOAD_LEN     = DEF_LOAD_LEN,
  parameter logic [ADDR_W-1:0] DUMP_BASE    = DEF_DUMP_BASE,
  parameter int                DUMP_LEN     = DEF_DUMP_LEN,
  parameter int                START_CYCLES = DEF_START_CYCLES,
  parameter int                TIMEOUT      = DEF_TIMEOUT
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              go_i,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_din_o,
  input  logic [DATA_W-1:0] mem_dout_i,
  output logic              cpu_start_o,
  input  logic              cpu_halt_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int CNT_MAX = (TIMEOUT > START_CYCLES) ? TIMEOUT : START_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [IDX_W-1:0] LOAD_LAST  = IDX_W'(LOAD_LEN - 1);
  localparam logic [IDX_W-1:0] DUMP_LAST  = IDX_W'(DUMP_LEN - 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(TIMEOUT - 1);

  localparam state_e GO_NEXT   = (LOAD_LEN == 0) ? S_START : S_LOAD;
  localparam state_e HALT_NEXT = (DUMP_LEN == 0) ? S_DONE  : S_DUMP;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             in_ready_q;
  logic             cpu_start_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             done_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (go_i) begin
          err_d   = 1'b0;
          state_d = GO_NEXT;
        end
      end
      S_LOAD: begin
        if (in_valid_i) begin
          if (idx_q == LOAD_LAST) state_d = S_START;
          else                    idx_d   = idx_q + 9'd1;
        end
      end
      S_START: begin
        if (cnt_q == START_LAST) state_d = S_RUN;
        else                     cnt_d   = cnt_q + CNT_W'(1);
      end
      S_RUN: begin
        // First RUN cycle (cnt_q == 0) masks a halt left over from the previous program.
        if (cpu_halt_i && (cnt_q != '0)) begin
          state_d = HALT_NEXT;
        end else if (cnt_q == RUN_LAST) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DUMP: begin
        if (out_ready_i) begin
          if (idx_q == DUMP_LAST) state_d = S_DONE;
          else                    idx_d   = idx_q + 9'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) begin
      idx_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      cpu_start_q <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      in_ready_q  <= (state_d == S_LOAD);
      cpu_start_q <= (state_d inside {S_IDLE, S_LOAD, S_START});
      out_valid_q <= (state_d == S_DUMP);
      busy_q      <= (state_d inside {S_LOAD, S_START, S_RUN, S_DUMP});
      done_q      <= (state_d == S_DONE);
    end
  end

  always_comb begin
    mem_addr_o = '0;
    case (state_q)
      S_LOAD:  mem_addr_o = wrap_addr(LOAD_BASE, idx_q);
      S_DUMP:  mem_addr_o = wrap_addr(DUMP_BASE, idx_q);
      default: mem_addr_o = '0;
    endcase
  end

  assign mem_we_o    = in_ready_q & in_valid_i;
  assign mem_din_o   = in_data_i;
  assign out_data_o  = mem_dout_i;
  assign in_ready_o  = in_ready_q;
  assign cpu_start_o = cpu_start_q;
  assign out_valid_o = out_valid_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_boot_sequencer.sv
// ============================================================================
//  Module   : tb_cpu_boot_sequencer
//  Purpose  : Self-checking bench for cpu_boot_sequencer with a data_mem model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_boot_sequencer;
  import cpu_boot_pkg::*;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, go, in_valid, in_ready, mem_we, cpu_start, cpu_halt;
  logic       out_valid, out_ready, busy, done, err;
  logic [7:0] in_data, mem_addr, mem_din, mem_dout, out_data;

  logic       t_go, t_in_valid, t_in_ready, t_mem_we, t_cpu_start, t_cpu_halt;
  logic       t_out_valid, t_out_ready, t_busy, t_done, t_err;
  logic [7:0] t_in_data, t_mem_addr, t_mem_din, t_mem_dout, t_out_data;

  cpu_boot_sequencer dut (
    .clk_i(clk), .reset_n_i(reset_n), .go_i(go), .in_valid_i(in_valid), .in_data_i(in_data),
    .in_ready_o(in_ready), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_din_o(mem_din),
    .mem_dout_i(mem_dout), .cpu_start_o(cpu_start), .cpu_halt_i(cpu_halt),
    .out_valid_o(out_valid), .out_data_o(out_data), .out_ready_i(out_ready),
    .busy_o(busy), .done_o(done), .err_o(err)
  );

  cpu_boot_sequencer #(.TIMEOUT(20)) dut_t (
    .clk_i(clk), .reset_n_i(reset_n), .go_i(t_go), .in_valid_i(t_in_valid), .in_data_i(t_in_data),
    .in_ready_o(t_in_ready), .mem_we_o(t_mem_we), .mem_addr_o(t_mem_addr), .mem_din_o(t_mem_din),
    .mem_dout_i(t_mem_dout), .cpu_start_o(t_cpu_start), .cpu_halt_i(t_cpu_halt),
    .out_valid_o(t_out_valid), .out_data_o(t_out_data), .out_ready_i(t_out_ready),
    .busy_o(t_busy), .done_o(t_done), .err_o(t_err)
  );

  assign t_mem_dout = 8'h00;

  // data_mem model: never-written locations return a fixed address pattern.
  function automatic logic [7:0] pat(input logic [7:0] a);
    return a ^ 8'hA5;
  endfunction

  bit [7:0]   mem [256];
  bit [255:0] wr_seen;
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr]     <= mem_din;
      wr_seen[mem_addr] <= 1'b1;
    end
  end
  assign mem_dout = wr_seen[mem_addr] ? mem[mem_addr] : pat(mem_addr);

  bit t_ov_seen;
  always @(posedge clk) if (t_out_valid) t_ov_seen <= 1'b1;

  int checks   = 0;
  int failures = 0;

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", nm, act, exp);
    end
  endtask

  task automatic chkn(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic       go;
    logic       iv;
    logic [7:0] data;
    logic       halt;
    logic       e_cs;
    logic       e_busy;
    logic       e_ird;
    logic       e_we;
    logic [7:0] e_addr;
  } vec_t;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } sb_t;

  sb_t  sb[$];
  vec_t tbl[14];

  task automatic push_dump_expect();
    for (int k = 0; k < DEF_DUMP_LEN; k++) begin
      logic [7:0] a;
      a = DEF_DUMP_BASE + 8'(k);
      sb.push_back('{a, pat(a)});
    end
  endtask

  task automatic dump_phase(input int want, input bit toggle, output int got);
    logic [7:0] held;
    bit         hold_chk;
    sb_t        e;
    got      = 0;
    hold_chk = 0;
    for (int c = 0; c < 200 && got < want; c++) begin
      @(negedge clk);
      cpu_halt  = 1'b0;
      out_ready = toggle ? c[0] : 1'b1;
      #1;
      if (out_valid) begin
        if (hold_chk) chk8("dump_stable", out_data, held);
        if (out_ready) begin
          if (sb.size() == 0) begin
            chkn("dump_unexpected_byte", 1, 0);
          end else begin
            e = sb.pop_front();
            chk8("dump_addr", mem_addr, e.addr);
            chk8("dump_data", out_data, e.data);
          end
          got++;
          hold_chk = 0;
        end else begin
          held     = out_data;
          hold_chk = 1;
        end
      end
    end
    chkn("dump_byte_count", got, want);
  endtask

  task automatic load_run_halt(input logic [39:0] bytes);
    int n;
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    #1;
    chk1("go_clears_done", done, 1'b0);
    chk1("go_raises_start", cpu_start, 1'b1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      in_valid = 1'b1;
      in_data  = bytes[8*k +: 8];
      #1;
      chk1("stream_we", mem_we, 1'b1);
      chk8("stream_addr", mem_addr, 8'(k));
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n = 0;
    while (cpu_start && n < 10) begin
      n++;
      @(negedge clk);
      #1;
    end
    chkn("start_cycles", n, DEF_START_CYCLES);
    repeat (5) @(negedge clk);
    cpu_halt = 1'b1;
    push_dump_expect();
  endtask

  logic [39:0] ld1, ld2;
  int          got, n;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; go = 1'b0; in_valid = 1'b0; in_data = 8'h00; cpu_halt = 1'b0; out_ready = 1'b0;
    t_go = 1'b0; t_in_valid = 1'b0; t_in_data = 8'h00; t_cpu_halt = 1'b0; t_out_ready = 1'b0;
    ld1 = {8'hfb, 8'hff, 8'hff, 8'h03, 8'h00};
    ld2 = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};

    //          go    iv    data   halt  cs    busy  ird   we    addr
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00};
    tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h01};
    tbl[3]  = '{1'b0, 1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h01};
    tbl[4]  = '{1'b0, 1'b1, 8'hff, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h02};
    tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h03};
    tbl[6]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h03};
    tbl[7]  = '{1'b0, 1'b1, 8'hff, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h03};
    tbl[8]  = '{1'b0, 1'b1, 8'hfb, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h04};
    tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[10] = '{1'b0, 1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[13] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    chk1("rst_cpu_start", cpu_start, 1'b1);
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_mem_we", mem_we, 1'b0);
    chk8("rst_mem_addr", mem_addr, 8'h00);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_err", err, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // Load with gaps, START window, stale halt at RUN entry
    for (int r = 0; r < 14; r++) begin
      @(negedge clk);
      go = tbl[r].go; in_valid = tbl[r].iv; in_data = tbl[r].data; cpu_halt = tbl[r].halt;
      #1;
      chk1($sformatf("row%0d_cpu_start", r), cpu_start, tbl[r].e_cs);
      chk1($sformatf("row%0d_busy", r), busy, tbl[r].e_busy);
      chk1($sformatf("row%0d_in_ready", r), in_ready, tbl[r].e_ird);
      chk1($sformatf("row%0d_mem_we", r), mem_we, tbl[r].e_we);
      chk8($sformatf("row%0d_mem_addr", r), mem_addr, tbl[r].e_addr);
      chk1($sformatf("row%0d_done", r), done, 1'b0);
      chk1($sformatf("row%0d_out_valid", r), out_valid, 1'b0);
    end
    go = 1'b0;

    // Halt about 40 cycles into RUN, then dump under toggling backpressure
    repeat (36) @(negedge clk);
    #1;
    chk1("run_still_busy", busy, 1'b1);
    chk1("run_no_out_valid", out_valid, 1'b0);
    @(negedge clk);
    cpu_halt = 1'b1;
    push_dump_expect();
    dump_phase(4, 1'b1, got);
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    chk1("dump_end_done", done, 1'b1);
    chk1("dump_end_busy", busy, 1'b0);
    chk1("dump_end_out_valid", out_valid, 1'b0);
    chk1("dump_end_cpu_start", cpu_start, 1'b0);
    chk1("dump_end_err", err, 1'b0);
    chkn("sb_empty", sb.size(), 0);
    for (int k = 0; k < 5; k++) chk8($sformatf("mem1_%0d", k), mem[k], ld1[8*k +: 8]);
    chkn("write_count", $countones(wr_seen), 5);

    // Reset mid-DUMP after two bytes, then a full clean run
    load_run_halt(ld2);
    dump_phase(2, 1'b0, got);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk1("mid_rst_cpu_start", cpu_start, 1'b1);
    chk1("mid_rst_out_valid", out_valid, 1'b0);
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_done", done, 1'b0);
    chk8("mid_rst_mem_addr", mem_addr, 8'h00);
    sb.delete();
    out_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    load_run_halt(ld1);
    dump_phase(4, 1'b1, got);
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    chk1("rerun_done", done, 1'b1);
    chkn("rerun_sb_empty", sb.size(), 0);
    for (int k = 0; k < 5; k++) chk8($sformatf("mem2_%0d", k), mem[k], ld1[8*k +: 8]);

    // Timeout on the TIMEOUT=20 instance
    @(negedge clk);
    t_go = 1'b1;
    @(negedge clk);
    t_go = 1'b0;
    t_in_valid = 1'b1;
    t_in_data  = 8'h3c;
    #1;
    chk8("t_mem_din", t_mem_din, 8'h3c);
    repeat (5) @(negedge clk);
    t_in_valid = 1'b0;
    #1;
    n = 0;
    while (t_cpu_start && n < 10) begin
      n++;
      @(negedge clk);
      #1;
    end
    chkn("t_start_cycles", n, DEF_START_CYCLES);
    chk1("t_run_no_we", t_mem_we, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      #1;
      if (k == 19) begin
        chk1("t_k19_busy", t_busy, 1'b1);
        chk1("t_k19_done", t_done, 1'b0);
        chk1("t_k19_err", t_err, 1'b0);
      end
      if (k == 20) begin
        chk1("t_k20_done", t_done, 1'b1);
        chk1("t_k20_err", t_err, 1'b1);
        chk1("t_k20_busy", t_busy, 1'b0);
        chk8("t_k20_addr", t_mem_addr, 8'h00);
        chk8("t_out_data_passthru", t_out_data, 8'h00);
      end
    end
    repeat (3) @(negedge clk);
    #1;
    chk1("t_err_sticky", t_err, 1'b1);
    chk1("t_never_out_valid", t_ov_seen, 1'b0);
    @(negedge clk);
    t_go = 1'b1;
    @(negedge clk);
    t_go = 1'b0;
    #1;
    chk1("t_go_clears_err", t_err, 1'b0);
    chk1("t_go_clears_done", t_done, 1'b0);
    chk1("t_go_in_ready", t_in_ready, 1'b1);
    chk1("t_go_cpu_start", t_cpu_start, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
